// File: rtl/mul_unit.sv
// Sequential signed WIDTHxWIDTH multiplier: one shift-add step per cycle, start/busy/done handshake.
// Optional build macro MUL_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module mul_unit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mul1,
    input  logic [WIDTH-1:0]     mul2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mulresult
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [WIDTH:0]  mcand_q;
    logic [WIDTH:0]  mplier_q;
    logic            neg_q;
    logic [PW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic [WIDTH:0]  mag1;
    logic [WIDTH:0]  mag2;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_d;
    logic [WIDTH:0]  mplier_d;
    logic [PW-1:0]   result_d;
    logic            last_step;

    // One extra bit so the magnitude of the most negative operand is exact.
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return ext[WIDTH] ? (~ext + {{WIDTH{1'b0}}, 1'b1}) : ext;
    endfunction

    always_comb begin
        mag1      = magnitude(mul1);
        mag2      = magnitude(mul2);
        addend    = PW'(mcand_q) << cnt_q;
        acc_d     = acc_q + (mplier_q[0] ? addend : '0);
        mplier_d  = mplier_q >> 1;
        result_d  = neg_q ? (~acc_d + {{(PW-1){1'b0}}, 1'b1}) : acc_d;
`ifdef MUL_EARLY_EXIT_EN
        last_step = (cnt_q == CW'(WIDTH - 1)) || (mplier_d == '0);
`else
        last_step = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mulresult <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_q  <= mag1;
                        mplier_q <= mag2;
                        neg_q    <= mul1[WIDTH-1] ^ mul2[WIDTH-1];
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        busy     <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_step) begin
                        mulresult <= result_d;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
